mmc1_sync_mapper: RTL and testbench

- Synchronous, parametrised successor of the team's MMC1B mapper. Replaces the romsel-edge-clocked register file with logic clocked only on m2.
- Adds a true consecutive-write filter, configurable PRG/CHR sizes, SUROM-style 512KB outer PRG banking, and a PRG-RAM enable mode switch.
- Sits between the cartridge-edge CPU/PPU buses and the on-board flash, SRAM and CIRAM chip selects.

---
 rtl/mmc1_sync_mapper.sv | 180 ++++++++++++++++++
 tb/tb_mmc1_sync_mapper.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_sync_mapper.sv
// mmc1_sync_mapper
// Fully synchronous MMC1-style mapper clocked only on the rising edge of M2.
// The five-write serial port loads the control, CHR and PRG bank registers.
// The bank registers are then decoded combinationally into flash, SRAM and
// CIRAM addresses and chip selects.
//
// Ports:
//   m2, reset              - CPU M2 (the only clock), synchronous active-high reset
//   romsel, cpu_rw_in      - /ROMSEL (active low), CPU R/W (1 = read)
//   cpu_addr_in/data_in    - CPU A14..A0 and D7..D0
//   cpu_addr_out           - PRG address bits [PRG_SIZE_LOG2-1:12]
//   cpu_wr_out/rd_out      - R/W pass-through and its inverse
//   cpu_flash_ce/sram_ce   - PRG flash select (= romsel), PRG-RAM select (active low)
//   ppu_addr_in            - PPU A13..A10
//   ppu_rd/wr_in/out       - PPU strobes, passed through
//   ppu_addr_out           - CHR address bits [CHR_SIZE_LOG2-1:10]
//   ppu_flash_ce/sram_ce   - CHR chip selects (active low)
//   ppu_ciram_a10/ce       - nametable A10 and CIRAM select
//   irq                    - never driven (high-Z)
//   led                    - lit while the CPU accesses ROM space
module mmc1_sync_mapper #(
    parameter int PRG_SIZE_LOG2 = 19,
    parameter int CHR_SIZE_LOG2 = 17,
    parameter int USE_CHR_RAM   = 0,
    parameter int SUROM_EN      = 1,
    parameter int MMC1A         = 0
) (
    input  logic                       m2,
    input  logic                       reset,
    input  logic                       romsel,
    input  logic                       cpu_rw_in,
    input  logic [14:0]                cpu_addr_in,
    input  logic [7:0]                 cpu_data_in,
    output logic [PRG_SIZE_LOG2-13:0]  cpu_addr_out,
    output logic                       cpu_wr_out,
    output logic                       cpu_rd_out,
    output logic                       cpu_flash_ce,
    output logic                       cpu_sram_ce,
    input  logic [13:10]               ppu_addr_in,
    input  logic                       ppu_rd_in,
    input  logic                       ppu_wr_in,
    output logic [CHR_SIZE_LOG2-11:0]  ppu_addr_out,
    output logic                       ppu_rd_out,
    output logic                       ppu_wr_out,
    output logic                       ppu_flash_ce,
    output logic                       ppu_sram_ce,
    output logic                       ppu_ciram_a10,
    output logic                       ppu_ciram_ce,
    output logic                       irq,
    output logic                       led
);

    // The outer 256KB PRG bank only exists on a full 512KB SUROM-style board.
    localparam bit SuromOuter = (SUROM_EN != 0) && (PRG_SIZE_LOG2 == 19);

    logic [4:0] control_q, control_d;
    logic [4:0] prgBank_q, prgBank_d;
    logic [4:0] chr0Bank_q, chr0Bank_d;
    logic [4:0] chr1Bank_q, chr1Bank_d;
    logic [3:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       prevWr_q, prevWr_d;

    logic       wrCycle;
    logic       acceptWr;
    logic [4:0] commitValue;
    logic [3:0] prgLow;
    logic [6:0] prgFull;
    logic [4:0] chrBank4k;
    logic [6:0] chrFull;
    logic       unusedBits;

    // Register file update. Reset wins over any write on the same edge.
    always_ff @(posedge m2) begin
        if (reset) begin
            control_q  <= 5'b01100;
            prgBank_q  <= 5'd0;
            chr0Bank_q <= 5'd0;
            chr1Bank_q <= 5'd0;
            shift_q    <= 4'd0;
            cnt_q      <= 3'd0;
            prevWr_q   <= 1'b0;
        end else begin
            control_q  <= control_d;
            prgBank_q  <= prgBank_d;
            chr0Bank_q <= chr0Bank_d;
            chr1Bank_q <= chr1Bank_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            prevWr_q   <= prevWr_d;
        end
    end

    // Serial-port next state. A write seen on the edge right after another
    // write is a CPU read-modify-write double store and is dropped entirely,
    // so only the first store of a back-to-back pair reaches the shifter.
    always_comb begin
        control_d   = control_q;
        prgBank_d   = prgBank_q;
        chr0Bank_d  = chr0Bank_q;
        chr1Bank_d  = chr1Bank_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wrCycle     = !romsel && !cpu_rw_in;
        acceptWr    = wrCycle && !prevWr_q;
        prevWr_d    = wrCycle;
        commitValue = {cpu_data_in[0], shift_q};
        if (acceptWr) begin
            if (cpu_data_in[7]) begin
                shift_d         = 4'd0;
                cnt_d           = 3'd0;
                control_d[3:2]  = 2'b11;
            end else if (cnt_q < 3'd4) begin
                shift_d = {cpu_data_in[0], shift_q[3:1]};
                cnt_d   = cnt_q + 3'd1;
            end else begin
                case (cpu_addr_in[14:13])
                    2'b00:   control_d  = commitValue;
                    2'b01:   chr0Bank_d = commitValue;
                    2'b10:   chr1Bank_d = commitValue;
                    default: prgBank_d  = commitValue;
                endcase
                shift_d = 4'd0;
                cnt_d   = 3'd0;
            end
        end
    end

    // PRG and CHR bank decode. The outer PRG bit is shared by every mode,
    // including the fixed first/last bank modes.
    always_comb begin
        prgLow = {prgBank_q[3:1], cpu_addr_in[14]};
        case (control_q[3:2])
            2'b10:   prgLow = cpu_addr_in[14] ? prgBank_q[3:0] : 4'h0;
            2'b11:   prgLow = cpu_addr_in[14] ? 4'hF : prgBank_q[3:0];
            default: prgLow = {prgBank_q[3:1], cpu_addr_in[14]};
        endcase
        prgFull = {(SuromOuter ? chr0Bank_q[4] : 1'b0), prgLow, cpu_addr_in[13:12]};

        if (control_q[4]) begin
            chrBank4k = ppu_addr_in[12] ? chr1Bank_q : chr0Bank_q;
        end else begin
            chrBank4k = {chr0Bank_q[4:1], ppu_addr_in[12]};
        end
        chrFull = {chrBank4k, ppu_addr_in[11:10]};
    end

    assign cpu_addr_out = prgFull[PRG_SIZE_LOG2-13:0];
    assign ppu_addr_out = chrFull[CHR_SIZE_LOG2-11:0];

    // Nametable mirroring selected by control[1:0].
    always_comb begin
        case (control_q[1:0])
            2'b00:   ppu_ciram_a10 = 1'b0;
            2'b01:   ppu_ciram_a10 = 1'b1;
            2'b10:   ppu_ciram_a10 = ppu_addr_in[10];
            default: ppu_ciram_a10 = ppu_addr_in[11];
        endcase
    end

    // PRG-RAM is qualified by M2 so the SRAM only sees the stable data phase.
    assign cpu_sram_ce  = ~(romsel & cpu_addr_in[14] & cpu_addr_in[13] & m2
                            & ((MMC1A != 0) | ~prgBank_q[4]));
    assign cpu_wr_out   = cpu_rw_in;
    assign cpu_rd_out   = ~cpu_rw_in;
    assign cpu_flash_ce = romsel;

    assign ppu_rd_out   = ppu_rd_in;
    assign ppu_wr_out   = ppu_wr_in;
    assign ppu_sram_ce  = (USE_CHR_RAM != 0) ? ppu_addr_in[13] : 1'b1;
    assign ppu_flash_ce = (USE_CHR_RAM != 0) ? 1'b1 : ppu_addr_in[13];
    assign ppu_ciram_ce = ~ppu_addr_in[13];

    assign irq = 1'bz;
    assign led = ~romsel;

    // Address and data bits the mapper never decodes.
    assign unusedBits = ^{cpu_addr_in[11:0], cpu_data_in[6:1], prgFull, chrFull};

endmodule

// File: tb/tb_mmc1_sync_mapper.sv
// tb_mmc1_sync_mapper
// Directed test-plan sequence followed by randomized traffic. Every output is
// compared against a behavioural model of the serial register file.
module tb_mmc1_sync_mapper;

    localparam int PrgLog2   = 19;
    localparam int ChrLog2   = 17;
    localparam int UseChrRam = 0;
    localparam int SuromEn   = 1;
    localparam int Mmc1a     = 0;

    logic        m2 = 1'b0;
    logic        reset;
    logic        romsel;
    logic        cpuRw;
    logic [14:0] cpuAddr;
    logic [7:0]  cpuData;
    logic [3:0]  ppuAddr;
    logic        ppuRd;
    logic        ppuWr;

    logic [PrgLog2-13:0] cpuAddrOut;
    logic [ChrLog2-11:0] ppuAddrOut;
    logic cpuWrOut, cpuRdOut, cpuFlashCe, cpuSramCe;
    logic ppuRdOut, ppuWrOut, ppuFlashCe, ppuSramCe, ppuCiramA10, ppuCiramCe;
    logic ledOut;
    wire  unusedIrq;

    // Model state: regs[0]=control, [1]=chr0, [2]=chr1, [3]=prg, which is
    // also the order of the A14..A13 register select.
    int regs [4];
    int bitsQ [$];
    bit prevWrM;
    bit modelValid = 1'b0;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    mmc1_sync_mapper #(
        .PRG_SIZE_LOG2 (PrgLog2),
        .CHR_SIZE_LOG2 (ChrLog2),
        .USE_CHR_RAM   (UseChrRam),
        .SUROM_EN      (SuromEn),
        .MMC1A         (Mmc1a)
    ) dut (
        .m2            (m2),
        .reset         (reset),
        .romsel        (romsel),
        .cpu_rw_in     (cpuRw),
        .cpu_addr_in   (cpuAddr),
        .cpu_data_in   (cpuData),
        .cpu_addr_out  (cpuAddrOut),
        .cpu_wr_out    (cpuWrOut),
        .cpu_rd_out    (cpuRdOut),
        .cpu_flash_ce  (cpuFlashCe),
        .cpu_sram_ce   (cpuSramCe),
        .ppu_addr_in   (ppuAddr),
        .ppu_rd_in     (ppuRd),
        .ppu_wr_in     (ppuWr),
        .ppu_addr_out  (ppuAddrOut),
        .ppu_rd_out    (ppuRdOut),
        .ppu_wr_out    (ppuWrOut),
        .ppu_flash_ce  (ppuFlashCe),
        .ppu_sram_ce   (ppuSramCe),
        .ppu_ciram_a10 (ppuCiramA10),
        .ppu_ciram_ce  (ppuCiramCe),
        .irq           (unusedIrq),
        .led           (ledOut)
    );

    // M2 clock, 10 time units per cycle.
    always #5 m2 = ~m2;

    // Behavioural register-file update for one M2 rising edge.
    function automatic void modelStep();
        bit wr;
        int value;
        if (reset) begin
            regs[0] = 12;
            regs[1] = 0;
            regs[2] = 0;
            regs[3] = 0;
            bitsQ.delete();
            prevWrM    = 1'b0;
            modelValid = 1'b1;
            return;
        end
        wr = (romsel == 1'b0) && (cpuRw == 1'b0);
        if (wr && !prevWrM) begin
            if (cpuData[7]) begin
                bitsQ.delete();
                regs[0] = regs[0] | 12;
            end else if (bitsQ.size() < 4) begin
                bitsQ.push_back(int'(cpuData[0]));
            end else begin
                value = 16 * int'(cpuData[0]);
                foreach (bitsQ[i]) value += bitsQ[i] << i;
                regs[int'(cpuAddr[14:13])] = value;
                bitsQ.delete();
            end
        end
        prevWrM = wr;
    endfunction

    function automatic int expCpuAddr();
        int mode = (regs[0] >> 2) & 3;
        int a14  = (int'(cpuAddr) >> 14) & 1;
        int low4 = regs[3] % 16;
        int bank;
        if (mode < 2)       bank = (low4 / 2) * 2 + a14;
        else if (mode == 2) bank = (a14 != 0) ? low4 : 0;
        else                bank = (a14 != 0) ? 15 : low4;
        if (SuromEn != 0 && PrgLog2 == 19) bank += 16 * (regs[1] / 16);
        return (bank * 4 + ((int'(cpuAddr) >> 12) & 3)) % (1 << (PrgLog2 - 12));
    endfunction

    function automatic int expPpuAddr();
        int a12 = (int'(ppuAddr) >> 2) & 1;
        int bank;
        if ((regs[0] & 16) == 0) bank = (regs[1] / 2) * 2 + a12;
        else                     bank = (a12 != 0) ? regs[2] : regs[1];
        return (bank * 4 + (int'(ppuAddr) & 3)) % (1 << (ChrLog2 - 10));
    endfunction

    function automatic int expMirror();
        case (regs[0] % 4)
            0:       return 0;
            1:       return 1;
            2:       return int'(ppuAddr) & 1;
            default: return (int'(ppuAddr) >> 1) & 1;
        endcase
    endfunction

    function automatic int expSramCe();
        bit sel;
        sel = romsel && cpuAddr[14] && cpuAddr[13] && m2 && (Mmc1a != 0 || regs[3] < 16);
        return sel ? 0 : 1;
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model for the current inputs and state.
    task automatic checkAll(input string phase);
        int a13 = (int'(ppuAddr) >> 3) & 1;
        checkOutput({phase, ":cpu_addr_out"},  int'(cpuAddrOut),  expCpuAddr());
        checkOutput({phase, ":cpu_sram_ce"},   int'(cpuSramCe),   expSramCe());
        checkOutput({phase, ":ppu_addr_out"},  int'(ppuAddrOut),  expPpuAddr());
        checkOutput({phase, ":ppu_ciram_a10"}, int'(ppuCiramA10), expMirror());
        checkOutput({phase, ":ppu_flash_ce"},  int'(ppuFlashCe),  (UseChrRam != 0) ? 1 : a13);
        checkOutput({phase, ":ppu_sram_ce"},   int'(ppuSramCe),   (UseChrRam != 0) ? a13 : 1);
        checkOutput({phase, ":ppu_ciram_ce"},  int'(ppuCiramCe),  1 - a13);
        checkOutput({phase, ":cpu_flash_ce"},  int'(cpuFlashCe),  int'(romsel));
        checkOutput({phase, ":cpu_wr_out"},    int'(cpuWrOut),    int'(cpuRw));
        checkOutput({phase, ":cpu_rd_out"},    int'(cpuRdOut),    1 - int'(cpuRw));
        checkOutput({phase, ":led"},           int'(ledOut),      1 - int'(romsel));
        checkOutput({phase, ":ppu_rd_out"},    int'(ppuRdOut),    int'(ppuRd));
        checkOutput({phase, ":ppu_wr_out"},    int'(ppuWrOut),    int'(ppuWr));
    endtask

    // Drive one M2 cycle: inputs change on the falling edge, outputs are
    // checked in the low phase and again just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic rs, input logic rw,
                                 input logic [14:0] addr, input logic [7:0] data,
                                 input logic [3:0] ppu);
        @(negedge m2);
        reset   = rst;
        romsel  = rs;
        cpuRw   = rw;
        cpuAddr = addr;
        cpuData = data;
        ppuAddr = ppu;
        ppuRd   = 1'($urandom_range(0, 1));
        ppuWr   = 1'($urandom_range(0, 1));
        #1;
        if (modelValid) checkAll("low");
        @(posedge m2);
        modelStep();
        #1;
        checkAll("high");
    endtask

    // A mapper write followed by a ROM read, so the next write is accepted.
    task automatic spacedWrite(input logic [14:0] addr, input logic [7:0] data);
        applyStimulus(1'b0, 1'b0, 1'b0, addr, data, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 8'h00, 4'h0);
    endtask

    // Load a 5-bit register through the serial port, LSB first.
    task automatic commitReg(input logic [14:0] addr, input logic [4:0] value);
        for (int i = 0; i < 5; i++) spacedWrite(addr, {7'd0, value[i]});
    endtask

    // Idle CPU cycle (no ROM access) presenting a chosen address.
    task automatic idleAt(input logic [14:0] addr, input logic [3:0] ppu);
        applyStimulus(1'b0, 1'b1, 1'b1, addr, 8'h00, ppu);
    endtask

    initial begin
        reset = 1'b1; romsel = 1'b1; cpuRw = 1'b1; cpuAddr = '0; cpuData = '0;
        ppuAddr = '0; ppuRd = 1'b1; ppuWr = 1'b1;

        // Reset state and fixed last bank.
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0000, 8'h00, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0000, 8'h01, 4'h0);
        idleAt(15'h4000, 4'h0);
        checkOutput("tp_reset_hi_bank", int'(cpuAddrOut), 'h3C);
        idleAt(15'h0000, 4'h0);
        checkOutput("tp_reset_lo_bank", int'(cpuAddrOut), 'h00);

        // PRG bank load through five spaced writes.
        commitReg(15'h6000, 5'b00101);
        idleAt(15'h0000, 4'h0);
        checkOutput("tp_prg_bank", int'(cpuAddrOut), 'h14);

        // Back-to-back pair counts once; the sixth write commits control.
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15'h0000, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) spacedWrite(15'h0000, 8'h00);
        idleAt(15'h4000, 4'h0);
        checkOutput("tp_pair_no_commit", int'(cpuAddrOut), 'h3C);
        spacedWrite(15'h0000, 8'h00);
        idleAt(15'h4000, 4'h0);
        checkOutput("tp_pair_control0", int'(cpuAddrOut), 'h14);

        // Bit-7 write clears the shifter and forces the fixed-last-bank mode.
        for (int i = 0; i < 3; i++) spacedWrite(15'h0000, 8'h01);
        spacedWrite(15'h0000, 8'h80);
        idleAt(15'h4000, 4'h0);
        checkOutput("tp_reset_write", int'(cpuAddrOut), 'h3C);
        commitReg(15'h2000, 5'b00000);

        // Outer 256KB bank and PRG-RAM disable.
        commitReg(15'h2000, 5'b10000);
        idleAt(15'h4000, 4'h0);
        checkOutput("tp_surom_outer", int'(cpuAddrOut), 'h7C);
        idleAt(15'h6000, 4'h0);
        checkOutput("tp_sram_enabled", int'(cpuSramCe), 0);
        commitReg(15'h6000, 5'b10000);
        idleAt(15'h6000, 4'h0);
        checkOutput("tp_sram_disabled", int'(cpuSramCe), 1);

        // 4KB CHR mode and mirroring from A11.
        commitReg(15'h0000, 5'b10011);
        commitReg(15'h4000, 5'b00111);
        idleAt(15'h0000, 4'b0100);
        checkOutput("tp_chr_4k_bank1", int'(ppuAddrOut), 'h1C);
        idleAt(15'h0000, 4'b0010);
        checkOutput("tp_mirror_a11", int'(ppuCiramA10), 1);

        // Reset in the middle of a sequence drops the partial value.
        spacedWrite(15'h6000, 8'h01);
        spacedWrite(15'h6000, 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0000, 8'h00, 4'h0);
        commitReg(15'h6000, 5'b00010);
        idleAt(15'h0000, 4'h0);
        checkOutput("tp_mid_reset", int'(cpuAddrOut), 'h08);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) != 0) d[7] = 1'b0;
            applyStimulus(1'($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 2) == 0),
                          15'($urandom_range(0, 32767)),
                          d,
                          4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
